// File: rtl/hold_ctrl.sv
// Pipeline hold/flush scheduler: merges stall sources into one hold_flag bus,
// forwards jump redirects, sequences post-jump flushes, debug halt and a stall watchdog.
module hold_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_ex_i,
    input  logic             hold_clint_i,
    input  logic             hold_jtag_i,
    input  logic             hold_rib_i,
    input  logic             timeout_clr_i,
    output logic [2:0]       hold_flag_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             halted_o,
    output logic             stall_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [2:0]       HOLD_NONE = 3'd0;
    localparam logic [2:0]       HOLD_PC   = 3'd1;
    localparam logic [2:0]       HOLD_IF   = 3'd2;
    localparam logic [2:0]       HOLD_ID   = 3'd3;
    localparam logic [3:0]       FLUSH_LD  = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       flush_cnt_reg, flush_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             timeout_reg, timeout_next;
    logic             halted_reg;

    logic [2:0]       req_lvl;
    logic             stall_req;
    logic             timeout_set;
    logic [CNT_W-1:0] stall_inc;

    // Highest-priority active request; EX and CLINT both need the whole front end frozen.
    always_comb begin
        req_lvl = HOLD_NONE;
        if (hold_ex_i || (hold_clint_i && state_reg != ST_HALT)) begin
            req_lvl = HOLD_ID;
        end else if (hold_rib_i) begin
            req_lvl = HOLD_PC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= 4'd0;
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            timeout_reg   <= timeout_next;
            halted_reg    <= (state_next == ST_HALT);
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        hold_flag_o    = HOLD_NONE;
        jump_flag_o    = 1'b0;
        jump_addr_o    = 32'd0;
        case (state_reg)
            ST_RUN: begin
                if (jump_flag_i) begin
                    hold_flag_o = HOLD_ID;
                    jump_flag_o = 1'b1;
                    jump_addr_o = jump_addr_i;
                    if (FLUSH_CYCLES > 0) begin
                        state_next     = ST_FLUSH;
                        flush_cnt_next = FLUSH_LD;
                    end
                end else if (hold_jtag_i) begin
                    hold_flag_o = HOLD_ID;
                    state_next  = ST_HALT;
                end else begin
                    hold_flag_o = req_lvl;
                end
            end
            ST_FLUSH: begin
                if (jump_flag_i) begin
                    hold_flag_o    = HOLD_ID;
                    jump_flag_o    = 1'b1;
                    jump_addr_o    = jump_addr_i;
                    flush_cnt_next = FLUSH_LD;
                end else begin
                    hold_flag_o    = (req_lvl > HOLD_IF) ? req_lvl : HOLD_IF;
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                    if (flush_cnt_reg == 4'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                hold_flag_o = HOLD_ID;
                if (!hold_jtag_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Watchdog counts only stalls that can wedge a running core; debug halt freezes it.
    always_comb begin
        stall_req   = hold_ex_i | hold_rib_i;
        stall_inc   = (stall_cnt_reg == {CNT_W{1'b1}}) ? stall_cnt_reg : stall_cnt_reg + 1'b1;
        timeout_set = 1'b0;
        if (!stall_req) begin
            stall_cnt_next = '0;
        end else if (state_reg != ST_HALT) begin
            stall_cnt_next = stall_inc;
            timeout_set    = (stall_inc == TIMEOUT_C);
        end else begin
            stall_cnt_next = stall_cnt_reg;
        end
        timeout_next = timeout_set | (timeout_reg & ~timeout_clr_i);
    end

    assign halted_o        = halted_reg;
    assign stall_timeout_o = timeout_reg;
    assign stall_cnt_o     = stall_cnt_reg;

endmodule

// File: tb/tb_hold_ctrl.sv
// Directed and randomized check of hold_ctrl against a cycle-level behavioural model.
module tb_hold_ctrl;

    localparam int FC     = 2;
    localparam int TO     = 8;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          jump_flag_i;
    logic [31:0]   jump_addr_i;
    logic          hold_ex_i, hold_clint_i, hold_jtag_i, hold_rib_i, timeout_clr_i;
    logic [2:0]    hold_flag_o;
    logic          jump_flag_o;
    logic [31:0]   jump_addr_o;
    logic          halted_o, stall_timeout_o;
    logic [CW-1:0] stall_cnt_o;

    int vectors = 0;
    int errors  = 0;

    // Model state: remaining Hold_If cycles, halt flag, stall run length, sticky timeout.
    int m_flush_left;
    bit m_halt;
    int m_scnt;
    bit m_tflag;

    hold_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_clint_i(hold_clint_i),
        .hold_jtag_i(hold_jtag_i), .hold_rib_i(hold_rib_i),
        .timeout_clr_i(timeout_clr_i),
        .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .halted_o(halted_o), .stall_timeout_o(stall_timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        m_halt       = 0;
        m_scnt       = 0;
        m_tflag      = 0;
    endtask

    // Drive one cycle's inputs at the falling edge, check, then advance the model at the edge.
    task automatic step(input bit j, input logic [31:0] a, input bit ex, input bit cl,
                        input bit jt, input bit rb, input bit clr);
        int  req, eh, ncnt;
        bit  ej, stall, nhalt;
        jump_flag_i = j; jump_addr_i = a; hold_ex_i = ex; hold_clint_i = cl;
        hold_jtag_i = jt; hold_rib_i = rb; timeout_clr_i = clr;
        #1;
        req   = (ex || cl) ? 3 : (rb ? 1 : 0);
        ej    = 0;
        nhalt = m_halt;
        if (m_halt) begin
            eh    = 3;
            nhalt = jt;
        end else if (j) begin
            eh = 3; ej = 1;
            m_flush_left = FC;
        end else if (m_flush_left > 0) begin
            eh = (req > 2) ? req : 2;
            m_flush_left--;
        end else if (jt) begin
            eh    = 3;
            nhalt = 1;
        end else begin
            eh = req;
        end
        $display("t=%0t j=%0d ex=%0d cl=%0d jt=%0d rb=%0d clr=%0d -> hold=%0d jf=%0d halted=%0d to=%0d cnt=%0d",
                 $time, j, ex, cl, jt, rb, clr, hold_flag_o, jump_flag_o, halted_o,
                 stall_timeout_o, stall_cnt_o);
        chk("hold_flag", 32'(hold_flag_o), 32'(eh));
        chk("jump_flag", 32'(jump_flag_o), 32'(ej));
        chk("jump_addr", jump_addr_o, ej ? a : 32'd0);
        chk("halted", 32'(halted_o), 32'(m_halt));
        chk("stall_timeout", 32'(stall_timeout_o), 32'(m_tflag));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_scnt));
        stall = ex || rb;
        ncnt  = m_scnt;
        if (!stall) ncnt = 0;
        else if (!m_halt) ncnt = (m_scnt == CNTMAX) ? CNTMAX : m_scnt + 1;
        if (stall && !m_halt && ncnt == TO) m_tflag = 1;
        else if (clr) m_tflag = 0;
        m_scnt = ncnt;
        m_halt = nhalt;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
    task automatic async_reset();
        jump_flag_i = 0; jump_addr_i = 0; hold_ex_i = 0; hold_clint_i = 0;
        hold_jtag_i = 0; hold_rib_i = 0; timeout_clr_i = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_hold_flag", 32'(hold_flag_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_timeout", 32'(stall_timeout_o), 32'd0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit jt_lvl;
        rst = 1'b1;
        jump_flag_i = 0; jump_addr_i = 0; hold_ex_i = 0; hold_clint_i = 0;
        hold_jtag_i = 0; hold_rib_i = 0; timeout_clr_i = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_hold_flag", 32'(hold_flag_o), 32'd0);
        chk("reset_jump_flag", 32'(jump_flag_o), 32'd0);
        chk("reset_jump_addr", jump_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Jump then flush: 3, 2, 2, 0
        step(1, 32'h0000_0100, 0, 0, 0, 0, 0);
        idle(3);

        // Priority merge, including RIB request inside a flush
        step(0, 32'd0, 1, 0, 0, 1, 0);
        step(0, 32'd0, 0, 0, 0, 1, 0);
        step(1, 32'h0000_0200, 0, 0, 0, 0, 0);
        step(0, 32'd0, 0, 0, 0, 1, 0);
        step(0, 32'd0, 0, 1, 0, 0, 0);
        idle(2);

        // Debug halt with a jump attempted while halted
        step(0, 32'd0, 0, 0, 1, 0, 0);
        step(0, 32'd0, 0, 0, 1, 0, 0);
        step(1, 32'h0000_0300, 0, 1, 1, 0, 0);
        step(0, 32'd0, 0, 0, 1, 0, 0);
        step(0, 32'd0, 0, 0, 1, 0, 0);
        idle(3);

        // Jump and halt together: jump wins, halt after flush
        step(1, 32'h0000_0400, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'd0, 0, 0, 1, 0, 0);
        idle(2);

        // Watchdog: 8 stall cycles, release, clear; then saturation and set-beats-clear
        async_reset();
        for (int i = 0; i < TO; i++) step(0, 32'd0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 32'd0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < TO - 1; i++) step(0, 32'd0, 1, 0, 0, 0, 0);
        step(0, 32'd0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 32'd0, 0, 0, 0, 1, 0);
        step(0, 32'd0, 0, 0, 0, 1, 1);
        idle(1);

        // Reset mid-flush
        step(1, 32'h0000_0500, 0, 0, 0, 0, 0);
        step(0, 32'd0, 0, 0, 0, 0, 0);
        async_reset();
        idle(2);

        // Randomized traffic; debug halt kept as a slowly toggling level
        jt_lvl = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) jt_lvl = ~jt_lvl;
            step($urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, jt_lvl,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
